// File: rtl/stream_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_pkg
// Brief    : Shared mode constants, arbiter state type and index helper for
//            the streaming multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
package stream_mux_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Increment a channel index, wrapping at n (n need not be a power of two).
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage : stream_mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational arbiter; round-robin from ptr or fixed lowest-index
//            priority, producing a one-hot grant and its encoded index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             mode,
    output logic [N_CH-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_valid
);

    int w_start;
    int w_idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        w_idx       = 0;
        w_start     = (mode == MODE_FIXED) ? 0 : int'(ptr);
        // Walk every channel once starting at w_start; the first requester wins.
        for (int i = 0; i < N_CH; i++) begin
            w_idx = w_start + i;
            if (w_idx >= N_CH) begin
                w_idx = w_idx - N_CH;
            end
            if (!grant_valid && req[w_idx]) begin
                grant_valid  = 1'b1;
                grant_idx    = SEL_W'(w_idx);
                grant[w_idx] = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/stream_mux_arb.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_arb
// Brief    : N-channel valid/ready stream multiplexer with internal
//            round-robin / fixed-priority arbitration and packet locking.
// Revision : 1.0 - initial release
// ============================================================================
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH-1:0]   in_last,
    output logic [N_CH-1:0]   in_ready,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [SEL_W-1:0] r_lock_ch;
    logic [SEL_W-1:0] w_lock_ch_nxt;
    logic             r_lock_mode;
    logic             w_lock_mode_nxt;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptr_nxt;

    logic [N_CH-1:0]  w_arb_grant;
    logic [SEL_W-1:0] w_arb_idx;
    logic             w_arb_valid;
    logic [N_CH-1:0]  w_grant;
    logic [SEL_W-1:0] w_grant_idx;
    logic             w_load_en;
    logic             w_xfer;
    logic             w_xfer_last;
    logic [W-1:0]     w_xfer_data;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req         (in_valid),
        .ptr         (r_ptr),
        .mode        (mode),
        .grant       (w_arb_grant),
        .grant_idx   (w_arb_idx),
        .grant_valid (w_arb_valid)
    );

    assign w_load_en = !out_valid | out_ready;

    // A held lock overrides the arbiter entirely, including the mode input.
    always_comb begin
        w_grant     = w_arb_valid ? w_arb_grant : '0;
        w_grant_idx = w_arb_idx;
        if (r_state == ARB_LOCKED) begin
            w_grant     = {{(N_CH-1){1'b0}}, 1'b1} << r_lock_ch;
            w_grant_idx = r_lock_ch;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ready
        assign in_ready[k] = w_load_en & w_grant[k] & in_valid[k];
    end

    assign w_xfer = |in_ready;

    always_comb begin
        w_xfer_data = '0;
        w_xfer_last = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_grant[k]) begin
                w_xfer_data = in_data[k*W +: W];
                w_xfer_last = in_last[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ARB_IDLE;
            r_lock_ch   <= '0;
            r_lock_mode <= MODE_RR;
            r_ptr       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_lock_ch   <= w_lock_ch_nxt;
            r_lock_mode <= w_lock_mode_nxt;
            r_ptr       <= w_ptr_nxt;
        end
    end

    // The mode seen when a packet starts decides whether its release advances ptr.
    always_comb begin
        w_state_nxt     = r_state;
        w_lock_ch_nxt   = r_lock_ch;
        w_lock_mode_nxt = r_lock_mode;
        w_ptr_nxt       = r_ptr;
        case (r_state)
            ARB_IDLE: begin
                if (w_xfer) begin
                    if (!w_xfer_last) begin
                        w_state_nxt     = ARB_LOCKED;
                        w_lock_ch_nxt   = w_grant_idx;
                        w_lock_mode_nxt = mode;
                    end else if (mode == MODE_RR) begin
                        w_ptr_nxt = SEL_W'(wrap_inc(int'(w_grant_idx), N_CH));
                    end
                end
            end
            ARB_LOCKED: begin
                if (w_xfer && w_xfer_last) begin
                    w_state_nxt = ARB_IDLE;
                    if (r_lock_mode == MODE_RR) begin
                        w_ptr_nxt = SEL_W'(wrap_inc(int'(r_lock_ch), N_CH));
                    end
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else if (w_load_en) begin
            out_valid <= w_xfer;
            if (w_xfer) begin
                out_data <= w_xfer_data;
                out_ch   <= w_grant_idx;
                out_last <= w_xfer_last;
            end
        end
    end

endmodule : stream_mux_arb
`default_nettype wire

// File: tb/tb_stream_mux_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_mux_arb
// Brief    : Directed self-checking bench for stream_mux_arb (N_CH=4, W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux_arb;

    logic        clk;
    logic        rst;
    logic        mode;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    int total;
    int bad;

    stream_mux_arb #(
        .N_CH (4),
        .W    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int k, input logic [7:0] d);
        in_data[k*8 +: 8] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; in_data = '0; in_valid = '0; in_last = '0; out_ready = 1'b1;
        repeat (2) tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", out_data); end
        total++; if (out_ch !== 2'd0) begin bad++; $display("FAIL reset_ch got=%0d exp=0", out_ch); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", out_last); end
        @(negedge clk); rst = 1'b0;
        #1;
        total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", in_ready); end
    endtask

    task automatic test_round_robin();
        mode = 1'b0; in_valid = 4'b1111; in_last = 4'b1111;
        for (int k = 0; k < 4; k++) set_data(k, 8'hC0 | 8'(k));
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL rr_first_ready got=%b exp=0001", in_ready); end
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_ch !== 2'(i % 4) || out_data !== (8'hC0 | 8'(i % 4))) begin
                bad++; $display("FAIL rr_beat%0d got v=%b ch=%0d d=%h exp v=1 ch=%0d", i, out_valid, out_ch, out_data, i % 4);
            end
        end
        in_valid = '0; tick();
    endtask

    task automatic test_fixed_priority();
        mode = 1'b1; in_valid = 4'b1010; in_last = 4'b1111;
        set_data(1, 8'h11); set_data(3, 8'h33);
        #1;
        total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL fixed_ready got=%b exp=0010", in_ready); end
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h11) begin
                bad++; $display("FAIL fixed_beat%0d got v=%b ch=%0d d=%h exp v=1 ch=1 d=11", i, out_valid, out_ch, out_data);
            end
        end
        in_valid = '0; tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fixed_drain got=%b exp=0", out_valid); end
        mode = 1'b0;
    endtask

    task automatic test_packet_lock();
        in_valid = 4'b0100; in_last = 4'b0000; set_data(2, 8'h21);
        #1;
        total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL lock_start_ready got=%b exp=0100", in_ready); end
        tick();
        total++; if (out_ch !== 2'd2 || out_data !== 8'h21 || out_last !== 1'b0) begin bad++; $display("FAIL lock_beat0 got ch=%0d d=%h l=%b exp ch=2 d=21 l=0", out_ch, out_data, out_last); end
        in_valid = 4'b0101; in_last = 4'b0001; set_data(0, 8'h01); set_data(2, 8'h22);
        #1;
        total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL lock_hold_ready got=%b exp=0100", in_ready); end
        tick();
        total++; if (out_ch !== 2'd2 || out_data !== 8'h22) begin bad++; $display("FAIL lock_beat1 got ch=%0d d=%h exp ch=2 d=22", out_ch, out_data); end
        in_last = 4'b0101; set_data(2, 8'h23);
        tick();
        total++; if (out_ch !== 2'd2 || out_data !== 8'h23 || out_last !== 1'b1) begin bad++; $display("FAIL lock_beat2 got ch=%0d d=%h l=%b exp ch=2 d=23 l=1", out_ch, out_data, out_last); end
        // ptr is now 3: channel 3 must beat channel 0.
        in_valid = 4'b1101; in_last = 4'b1101; set_data(3, 8'h03); set_data(2, 8'h24);
        #1;
        total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL lock_ptr_ready got=%b exp=1000", in_ready); end
        tick();
        total++; if (out_ch !== 2'd3 || out_data !== 8'h03) begin bad++; $display("FAIL lock_after3 got ch=%0d d=%h exp ch=3 d=03", out_ch, out_data); end
        tick();
        total++; if (out_ch !== 2'd0 || out_data !== 8'h01) begin bad++; $display("FAIL lock_after0 got ch=%0d d=%h exp ch=0 d=01", out_ch, out_data); end
        tick();
        total++; if (out_ch !== 2'd2 || out_data !== 8'h24) begin bad++; $display("FAIL lock_after2 got ch=%0d d=%h exp ch=2 d=24", out_ch, out_data); end
        in_valid = '0; tick();
    endtask

    task automatic test_back_pressure();
        in_valid = 4'b0010; in_last = 4'b0010; set_data(1, 8'hA5); out_ready = 1'b0;
        #1;
        total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL bp_empty_ready got=%b exp=0010", in_ready); end
        tick();
        set_data(1, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd1) begin
                bad++; $display("FAIL bp_hold%0d got rdy=%b v=%b d=%h ch=%0d exp rdy=0000 v=1 d=a5 ch=1", i, in_ready, out_valid, out_data, out_ch);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL bp_release_ready got=%b exp=0010", in_ready); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin bad++; $display("FAIL bp_next got v=%b d=%h exp v=1 d=5a", out_valid, out_data); end
        in_valid = '0; tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_mode_change();
        mode = 1'b0; in_valid = 4'b1001; in_last = 4'b0001; set_data(0, 8'h01); set_data(3, 8'h31);
        #1;
        total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL mc_first_ready got=%b exp=1000", in_ready); end
        tick();
        mode = 1'b1; set_data(3, 8'h32);
        #1;
        total++; if (in_ready !== 4'b1000) begin bad++; $display("FAIL mc_locked_ready got=%b exp=1000", in_ready); end
        tick();
        total++; if (out_ch !== 2'd3 || out_data !== 8'h32) begin bad++; $display("FAIL mc_beat1 got ch=%0d d=%h exp ch=3 d=32", out_ch, out_data); end
        in_last = 4'b1001; set_data(3, 8'h33);
        tick();
        total++; if (out_ch !== 2'd3 || out_data !== 8'h33 || out_last !== 1'b1) begin bad++; $display("FAIL mc_beat2 got ch=%0d d=%h l=%b exp ch=3 d=33 l=1", out_ch, out_data, out_last); end
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL mc_fixed_ready got=%b exp=0001", in_ready); end
        tick();
        total++; if (out_ch !== 2'd0 || out_data !== 8'h01) begin bad++; $display("FAIL mc_after got ch=%0d d=%h exp ch=0 d=01", out_ch, out_data); end
        in_valid = '0; mode = 1'b0; tick();
    endtask

    task automatic test_reset_mid_packet();
        in_valid = 4'b0010; in_last = 4'b0010; set_data(1, 8'h12);
        tick();
        in_valid = 4'b0100; in_last = 4'b0000; set_data(2, 8'h2F);
        tick();
        total++; if (out_valid !== 1'b1 || out_ch !== 2'd2) begin bad++; $display("FAIL rm_pre got v=%b ch=%0d exp v=1 ch=2", out_valid, out_ch); end
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0 || out_last !== 1'b0) begin
            bad++; $display("FAIL rm_async got v=%b d=%h ch=%0d l=%b exp all 0", out_valid, out_data, out_ch, out_last);
        end
        @(negedge clk); rst = 1'b0;
        in_valid = 4'b1111; in_last = 4'b1111;
        for (int k = 0; k < 4; k++) set_data(k, 8'hE0 | 8'(k));
        #1;
        total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL rm_idle_ptr0 got=%b exp=0001", in_ready); end
        tick();
        total++; if (out_ch !== 2'd0 || out_data !== 8'hE0) begin bad++; $display("FAIL rm_after got ch=%0d d=%h exp ch=0 d=e0", out_ch, out_data); end
        in_valid = '0; tick();
    endtask

    task automatic test_sparse();
        logic pat [7];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        in_last = 4'b1111;
        for (int i = 0; i < 7; i++) begin
            in_valid = pat[i] ? 4'b1000 : 4'b0000;
            set_data(3, 8'h30 + 8'(i));
            tick();
            total++;
            if (out_valid !== pat[i]) begin bad++; $display("FAIL sparse_valid%0d got=%b exp=%b", i, out_valid, pat[i]); end
            if (pat[i]) begin
                total++;
                if (out_ch !== 2'd3 || out_data !== (8'h30 + 8'(i))) begin
                    bad++; $display("FAIL sparse_beat%0d got ch=%0d d=%h exp ch=3 d=%h", i, out_ch, out_data, 8'h30 + 8'(i));
                end
            end
        end
        in_valid = '0; tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_packet_lock();
        test_back_pressure();
        test_mode_change();
        test_reset_mid_packet();
        test_sparse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_stream_mux_arb
`default_nettype wire

// File: doc/stream_mux_arb.md
# stream_mux_arb

Parametrised N-channel streaming multiplexer with a registered output and valid/ready handshakes; the selection that `mux8`/`mux16` take from a select input is instead made internally by an arbiter. Arbitration is round-robin or fixed-priority, and once a multi-beat packet starts it is held until its last beat. The block sits between several producer streams and one consumer. It is the handshaked, generalised successor to the combinational muxes.

## Interface
- `N_CH`, default 4: number of input channels, 2..16.
- `W`, default 8: data width per channel.
- `SEL_W`, default `$clog2(N_CH)`: width of the channel index. Derived; do not override.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `mode` input 1: arbitration mode. 0 = round-robin, 1 = fixed priority (lowest index wins).
- `in_data` input `N_CH*W`: channel k occupies bits `[k*W +: W]`.
- `in_valid` input `N_CH`: per-channel valid.
- `in_last` input `N_CH`: per-channel end-of-packet flag, qualified by valid.
- `in_ready` output `N_CH`: per-channel ready. At most one bit is high.
- `out_data` output `W`: registered data.
- `out_ch` output `SEL_W`: source channel of `out_data`.
- `out_last` output 1: registered last flag.
- `out_valid` output 1: output register holds a beat.
- `out_ready` input 1: consumer accepts the beat.

## Operation
- **Load enable:** `load_en = !out_valid | out_ready`.
  - `in_ready` depends combinationally on `out_ready`, `in_valid` and `mode`.
- **Transfer:** a beat transfers on channel k when `in_valid[k] & in_ready[k]`.
  - `in_ready[k] = load_en & (grant == k) & in_valid[k]`.
- **On transfer:** the output register captures data, k and last, and sets `out_valid` = 1.
- **Drain only:** on `load_en` with no transfer, `out_valid` clears.
- **Arbiter states:**
  - **IDLE:** grant goes to the winning valid channel.
    - Round-robin: search starts at `ptr` and wraps modulo `N_CH`.
    - Fixed: lowest valid index wins.
  - **LOCKED(c):** grant is c regardless of other valids or mode.
- **Transitions:**
  - IDLE to LOCKED(c): a transfer on c with `in_last` = 0.
  - LOCKED(c) to IDLE: a transfer on c with `in_last` = 1.
  - A single-beat packet (last = 1) stays in IDLE.
  - LOCKED with `in_valid[c]` = 0: no transfer, and the lock is held.
- **Round-robin pointer:** on each transfer that leaves the arbiter in IDLE (that is, a last beat from c), `ptr <= (c+1) mod N_CH`.
  - `ptr` holds in fixed mode and during a lock.
- **Mode change:** sampled only when the arbiter is in IDLE; it never breaks a lock.
- **No valid inputs:** no grant, `in_ready` all 0.
- **Reset:** `out_valid`=0, `out_data`=0, `out_ch`=0, `out_last`=0, `ptr`=0, state=IDLE.
  - Reset mid-packet drops the lock and any held beat.

## Timing
- Latency is 1 cycle from input transfer to `out_valid`.
- Full throughput: one beat per cycle while `out_ready` = 1.
- Back-pressure: with `out_valid` = 1 and `out_ready` = 0, `out_*` hold stable and every `in_ready` = 0.
- Arbitration for the next beat is evaluated in the same cycle the current beat drains. There are no bubble cycles.
- All state updates occur on `posedge clk`. `rst` acts immediately and asynchronously.

## Structure
- Package `stream_mux_pkg`:
  - mode constants `MODE_RR`=0 and `MODE_FIXED`=1;
  - arbiter state enum `{ARB_IDLE, ARB_LOCKED}`.
- Sub-module `rr_arbiter`, parameter `N_CH`:
  - inputs: `req`, `ptr`, `mode`;
  - outputs: one-hot grant and encoded index;
  - purely combinational.
- The top level holds `ptr`, the lock state and channel, and the output register.

## Test plan
- **Round-robin fairness:** `N_CH`=4, all valid with last=1, `out_ready`=1, mode=0 → `out_ch` sequence 0,1,2,3,0,… at one beat per cycle.
- **Fixed priority:** mode=1, channels 1 and 3 valid continuously → `out_ch` stays 1; channel 3 is never granted while 1 is valid.
- **Packet lock:** channel 2 sends 3 beats (last on the third) while channel 0 is valid → `out_ch` = 2,2,2, then 0; the round-robin pointer = 3 afterwards.
- **Back-pressure:** `out_ready`=0 for 5 cycles with data 0xA5 held → `out_data` stays 0xA5, all `in_ready`=0; the next beat is accepted the cycle `out_ready` rises.
- **Mid-packet events:**
  - Set mode=1 during a lock → the lock is held until last.
  - Assert `rst` mid-packet → `out_valid`=0 and state IDLE on the same cycle; `ptr`=0.
- **Sparse input:** a single channel (`N_CH`-1) valid, with gaps in `in_valid` → each beat appears after 1 cycle with correct `out_ch`, and `out_valid` drops during the gaps.
